exe_operand_forward: RTL and testbench

- Parametrised operand-forwarding stage for the execute path.
- Selects one source operand from the register file or from NUM_SRC forwarding sources, using address compare and fixed priority.
- Registers the result at the ID/EX boundary.
- While stalled, keeps snooping the forwarding buses so the held operand picks up results produced during the stall (late load-use forwarding).
- One instance per source operand (rs1, rs2).

---
 rtl/exe_operand_forward.sv | 123 ++++++++++++
 tb/tb_exe_operand_forward.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_operand_forward.sv
// Operand forwarding stage for one execute-path source operand (rs1 or rs2).
// Picks the operand from the register file or the youngest matching forwarding
// source, registers it at the ID/EX boundary, and keeps snooping the forwarding
// buses while stalled so a held operand can still pick up late results.
module exe_operand_forward #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  input  logic [REG_AW-1:0]           rs_addr_i,
  input  logic [DATA_W-1:0]           rf_data_i,
  input  logic [NUM_SRC-1:0]          fwd_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]   fwd_addr_i,
  input  logic [NUM_SRC*DATA_W-1:0]   fwd_data_i,
  output logic [DATA_W-1:0]           operand_o,
  output logic                        out_valid_o,
  output logic [SEL_W-1:0]            fwd_sel_o,
  output logic                        snoop_hit_o
);

  logic [DATA_W-1:0] operand_q, operand_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              hit_q, hit_d;
  logic [REG_AW-1:0] addr_q, addr_d;

  logic [DATA_W-1:0] cap_data;
  logic [SEL_W-1:0]  cap_sel;
  logic [DATA_W-1:0] snp_data;
  logic [SEL_W-1:0]  snp_sel;
  logic              snp_match;

  // Capture select for the incoming address; walk from the oldest source down so
  // the lowest matching index overwrites last and wins. x0 always reads as zero.
  always_comb begin
    cap_data = rf_data_i;
    cap_sel  = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && (fwd_addr_i[i*REG_AW +: REG_AW] == rs_addr_i)) begin
        cap_data = fwd_data_i[i*DATA_W +: DATA_W];
        cap_sel  = SEL_W'(i + 1);
      end
    end
    if (rs_addr_i == '0) begin
      cap_data = '0;
      cap_sel  = '0;
    end
  end

  // Snoop select against the held address; only a forwarding hit matters here,
  // the register file is never re-read during a stall.
  always_comb begin
    snp_data  = '0;
    snp_sel   = '0;
    snp_match = 1'b0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && (fwd_addr_i[i*REG_AW +: REG_AW] == addr_q)) begin
        snp_data  = fwd_data_i[i*DATA_W +: DATA_W];
        snp_sel   = SEL_W'(i + 1);
        snp_match = 1'b1;
      end
    end
    if (addr_q == '0) begin
      snp_data  = '0;
      snp_sel   = '0;
      snp_match = 1'b0;
    end
  end

  // Next-state: flush beats stall, stall beats advance.
  always_comb begin
    operand_d = operand_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    hit_d     = 1'b0;
    if (flush_i) begin
      operand_d = '0;
      sel_d     = '0;
      valid_d   = 1'b0;
    end else if (stall_i) begin
      if (valid_q && snp_match) begin
        operand_d = snp_data;
        sel_d     = snp_sel;
        hit_d     = 1'b1;
      end
    end else begin
      addr_d    = rs_addr_i;
      operand_d = cap_data;
      sel_d     = cap_sel;
      valid_d   = in_valid_i;
    end
  end

  // ID/EX boundary registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_q <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      operand_q <= operand_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      hit_q     <= hit_d;
      addr_q    <= addr_d;
    end
  end

  assign operand_o   = operand_q;
  assign fwd_sel_o   = sel_q;
  assign out_valid_o = valid_q;
  assign snoop_hit_o = hit_q;

endmodule

// File: tb/tb_exe_operand_forward.sv
// Self-checking bench for exe_operand_forward: a table of single-cycle capture
// vectors followed by hand-written stall, snoop, flush and reset sequences.
module tb_exe_operand_forward;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        in_valid_i;
  logic [4:0]  rs_addr_i;
  logic [31:0] rf_data_i;
  logic [2:0]  fwd_valid_i;
  logic [14:0] fwd_addr_i;
  logic [95:0] fwd_data_i;
  logic [31:0] operand_o;
  logic        out_valid_o;
  logic [1:0]  fwd_sel_o;
  logic        snoop_hit_o;

  exe_operand_forward dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .rs_addr_i   (rs_addr_i),
    .rf_data_i   (rf_data_i),
    .fwd_valid_i (fwd_valid_i),
    .fwd_addr_i  (fwd_addr_i),
    .fwd_data_i  (fwd_data_i),
    .operand_o   (operand_o),
    .out_valid_o (out_valid_o),
    .fwd_sel_o   (fwd_sel_o),
    .snoop_hit_o (snoop_hit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op;
    logic [1:0]  sel;
    logic        valid;
    logic        hit;
  } exp_t;

  typedef struct {
    logic [4:0]  rs;
    logic [31:0] rf;
    logic        iv;
    logic [2:0]  fv;
    logic [14:0] fa;
    logic [95:0] fd;
    logic [31:0] eop;
    logic [1:0]  esel;
    logic        ev;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [31:0] rf, input logic iv,
                       input logic [2:0] fv, input logic [14:0] fa, input logic [95:0] fd);
    rs_addr_i   = rs;
    rf_data_i   = rf;
    in_valid_i  = iv;
    fwd_valid_i = fv;
    fwd_addr_i  = fa;
    fwd_data_i  = fd;
  endtask

  task automatic push(input logic [31:0] op, input logic [1:0] sel, input logic v,
                      input logic h);
    exp_t e;
    e.op = op; e.sel = sel; e.valid = v; e.hit = h;
    sb_q.push_back(e);
  endtask

  // Advance one clock and compare the DUT against the oldest expected entry.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got op %h, required an entry", tag, operand_o);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".op"},    operand_o,           e.op);
      chk({tag, ".sel"},   {30'd0, fwd_sel_o},  {30'd0, e.sel});
      chk({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, e.valid});
      chk({tag, ".hit"},   {31'd0, snoop_hit_o}, {31'd0, e.hit});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".op"},    operand_o,            32'd0);
    chk({tag, ".sel"},   {30'd0, fwd_sel_o},   32'd0);
    chk({tag, ".valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({tag, ".hit"},   {31'd0, snoop_hit_o}, 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, required $finish before 20000");
    $fatal(1, "watchdog");
  end

  initial begin
    // fa packs {src2, src1, src0}; fd the same.
    vecs[0] = '{rs:5'd5,  rf:32'h11, iv:1'b1, fv:3'b000, fa:{5'd0, 5'd0, 5'd0},
                fd:96'd0, eop:32'h11, esel:2'd0, ev:1'b1};
    vecs[1] = '{rs:5'd5,  rf:32'h22, iv:1'b1, fv:3'b101, fa:{5'd5, 5'd0, 5'd5},
                fd:{32'hCC, 32'h0, 32'hAA}, eop:32'hAA, esel:2'd1, ev:1'b1};
    vecs[2] = '{rs:5'd5,  rf:32'h22, iv:1'b1, fv:3'b100, fa:{5'd5, 5'd0, 5'd5},
                fd:{32'hCC, 32'h0, 32'hAA}, eop:32'hCC, esel:2'd3, ev:1'b1};
    vecs[3] = '{rs:5'd0,  rf:32'hFFFF_FFFF, iv:1'b1, fv:3'b001, fa:{5'd0, 5'd0, 5'd0},
                fd:{32'h0, 32'h0, 32'h55}, eop:32'h0, esel:2'd0, ev:1'b1};
    vecs[4] = '{rs:5'd3,  rf:32'h33, iv:1'b0, fv:3'b010, fa:{5'd0, 5'd3, 5'd0},
                fd:{32'h0, 32'h77, 32'h0}, eop:32'h77, esel:2'd2, ev:1'b0};
    vecs[5] = '{rs:5'd9,  rf:32'h90, iv:1'b1, fv:3'b110, fa:{5'd9, 5'd9, 5'd0},
                fd:{32'h98, 32'h99, 32'h0}, eop:32'h99, esel:2'd2, ev:1'b1};
    vecs[6] = '{rs:5'd9,  rf:32'h90, iv:1'b1, fv:3'b111, fa:{5'd9, 5'd9, 5'd8},
                fd:{32'h98, 32'h99, 32'h88}, eop:32'h99, esel:2'd2, ev:1'b1};
    vecs[7] = '{rs:5'd31, rf:32'hDEAD_BEEF, iv:1'b1, fv:3'b000, fa:{5'd31, 5'd31, 5'd31},
                fd:{32'h1, 32'h2, 32'h3}, eop:32'hDEAD_BEEF, esel:2'd0, ev:1'b1};

    rst_n   = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(5'd0, 32'd0, 1'b0, 3'b000, 15'd0, 96'd0);
    #2;
    chk_zero("reset");
    #10;
    rst_n = 1'b1;

    // Table-driven capture vectors.
    for (int k = 0; k < 8; k++) begin
      drive(vecs[k].rs, vecs[k].rf, vecs[k].iv, vecs[k].fv, vecs[k].fa, vecs[k].fd);
      push(vecs[k].eop, vecs[k].esel, vecs[k].ev, 1'b0);
      step($sformatf("vec%0d", k));
    end

    // Load-use: capture x7 from the register file, then snoop during the stall.
    drive(5'd7, 32'h1, 1'b1, 3'b000, 15'd0, 96'd0);
    push(32'h1, 2'd0, 1'b1, 1'b0);
    step("lu_cap");
    stall_i = 1'b1;
    drive(5'd8, 32'hDEAD, 1'b1, 3'b000, 15'd0, 96'd0);
    push(32'h1, 2'd0, 1'b1, 1'b0);
    step("lu_stall1");
    drive(5'd8, 32'hDEAD, 1'b1, 3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'hBEEF, 32'h0});
    push(32'hBEEF, 2'd2, 1'b1, 1'b1);
    step("lu_stall2");
    drive(5'd8, 32'hDEAD, 1'b1, 3'b000, 15'd0, 96'd0);
    push(32'hBEEF, 2'd2, 1'b1, 1'b0);
    step("lu_stall3");
    drive(5'd8, 32'hDEAD, 1'b1, 3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hA1, 32'hA0});
    push(32'hA0, 2'd1, 1'b1, 1'b1);
    step("lu_stall4");
    stall_i = 1'b0;
    drive(5'd4, 32'h44, 1'b1, 3'b000, 15'd0, 96'd0);
    push(32'h44, 2'd0, 1'b1, 1'b0);
    step("lu_release");

    // Flush together with stall while a snoop match is present.
    drive(5'd6, 32'h66, 1'b1, 3'b000, 15'd0, 96'd0);
    push(32'h66, 2'd0, 1'b1, 1'b0);
    step("fl_cap");
    stall_i = 1'b1;
    flush_i = 1'b1;
    drive(5'd6, 32'h66, 1'b1, 3'b001, {5'd0, 5'd0, 5'd6}, {32'h0, 32'h0, 32'h123});
    push(32'h0, 2'd0, 1'b0, 1'b0);
    step("fl_flush");
    // A dead held operand must not snoop.
    flush_i = 1'b0;
    push(32'h0, 2'd0, 1'b0, 1'b0);
    step("fl_dead_snoop");
    stall_i = 1'b0;

    // Asynchronous reset between edges in the middle of a stall.
    drive(5'd10, 32'hABC, 1'b1, 3'b000, 15'd0, 96'd0);
    push(32'hABC, 2'd0, 1'b1, 1'b0);
    step("rs_cap");
    stall_i = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("rs_async");
    #2;
    rst_n   = 1'b1;
    stall_i = 1'b0;
    drive(5'd11, 32'h5, 1'b1, 3'b000, 15'd0, 96'd0);
    push(32'h5, 2'd0, 1'b1, 1'b0);
    step("rs_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
